// File: rtl/sprite_arb_pkg.sv
// Shared types and default sizes for the sprite ROM read-port arbiter.
package sprite_arb_pkg;

  localparam int ADDR_W_DEF  = 17;
  localparam int DATA_W_DEF  = 4;
  localparam int ROM_LAT_DEF = 1;

  // Widest client ID the arbiter supports (up to 8 clients).
  localparam int ID_W_MAX = 3;

  typedef logic [ID_W_MAX-1:0] req_id_t;

  // Pipeline tag that travels alongside a ROM read.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } arb_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick. The search starts at the client after
// `last` and wraps, so the most recently served client ranks lowest.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic [ID_W-1:0]    last,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_grant
);

  // First asserted request in rotated order wins; nothing is granted while disabled.
  always_comb begin
    int idx_s;
    grant     = '0;
    grant_id  = '0;
    any_grant = 1'b0;
    idx_s     = 0;
    if (en) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx_s = (int'(last) + k) % NUM_REQ;
        if (!any_grant && req[idx_s]) begin
          any_grant    = 1'b1;
          grant[idx_s] = 1'b1;
          grant_id     = ID_W'(idx_s);
        end else begin
          any_grant = any_grant;
        end
      end
    end else begin
      any_grant = 1'b0;
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM read port among several drawing clients.
// Round-robin grant, registered ROM address, and a tag pipeline that lines
// the returning palette index up with the client that asked for it.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ROM_LAT = ROM_LAT_DEF,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      vga_clk,
  input  logic                      Reset,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        grant,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_q,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data
);

  logic              arb_en_s;
  logic              any_grant_s;
  logic [ID_W-1:0]   grant_id_s;
  logic [ID_W-1:0]   last_r;
  logic [ADDR_W-1:0] sel_addr_s;
  arb_tag_t          new_tag_s;
  // Index ROM_LAT is the tag aligned with rom_q.
  arb_tag_t          tag_r [0:ROM_LAT];

  // Reset also blocks grants so nothing is accepted on the reset edge.
  assign arb_en_s = en & ~Reset;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req       (req),
    .en        (arb_en_s),
    .last      (last_r),
    .grant     (grant),
    .grant_id  (grant_id_s),
    .any_grant (any_grant_s)
  );

  // Select the granted client's address with a one-hot AND-OR mux.
  always_comb begin
    sel_addr_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr_s = sel_addr_s | req_addr[i*ADDR_W +: ADDR_W];
      end else begin
        sel_addr_s = sel_addr_s;
      end
    end
  end

  // Build the tag entering the pipeline this cycle; idle cycles inject an empty tag.
  always_comb begin
    new_tag_s = '0;
    if (any_grant_s) begin
      new_tag_s.valid = 1'b1;
      new_tag_s.id    = req_id_t'(grant_id_s);
    end else begin
      new_tag_s.valid = 1'b0;
      new_tag_s.id    = '0;
    end
  end

  // Issue register: capture the winning address and advance the fairness pointer.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      rom_addr <= '0;
      last_r   <= ID_W'(NUM_REQ - 1);
    end else if (any_grant_s) begin
      rom_addr <= sel_addr_s;
      last_r   <= grant_id_s;
    end else begin
      rom_addr <= rom_addr;
      last_r   <= last_r;
    end
  end

  // Tag shift register; reset drops every in-flight read.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      for (int i = 0; i <= ROM_LAT; i++) begin
        tag_r[i] <= '0;
      end
    end else begin
      tag_r[0] <= new_tag_s;
      for (int i = 1; i <= ROM_LAT; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  // Response register: strobe out rom_q with its client ID; hold the payload when idle.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else if (tag_r[ROM_LAT].valid) begin
      rsp_valid <= 1'b1;
      rsp_id    <= tag_r[ROM_LAT].id[ID_W-1:0];
      rsp_data  <= rom_q;
    end else begin
      rsp_valid <= 1'b0;
      rsp_id    <= rsp_id;
      rsp_data  <= rsp_data;
    end
  end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares one synchronous sprite ROM read port among up to `NUM_REQ` drawing clients: pixel pipeline, sprite engines and the text overlay. Each client posts a ROM address with a request/grant handshake. The block arbitrates round-robin, drives the ROM address, and returns the ROM's 4-bit palette index tagged with the client ID after a fixed latency. It sits between the drawing clients and the ROM, which feeds a palette lookup.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `ADDR_W`, default 17: ROM address width.
- `DATA_W`, default 4: ROM data width (palette index).
- `ROM_LAT`, default 1: ROM read latency in cycles, from address-sampling edge to valid `rom_q`.
- `vga_clk  in  1`: single clock. All logic is on the posedge.
- `Reset  in  1`: synchronous, active-high.
- `en  in  1`: when 0, no grants are issued (ROM reload or blanking freeze). Requests stay pending.
- `req  in  NUM_REQ`: per-client request level. Held until granted.
- `req_addr  in  NUM_REQ*ADDR_W`: packed addresses, client i at bits [i*ADDR_W +: ADDR_W]. Stable while `req[i]` is high.
- `grant  out  NUM_REQ`: one-hot, combinational, asserted in the accepting cycle.
- `rom_addr  out  ADDR_W`: registered ROM address.
- `rom_q  in  DATA_W`: ROM read data.
- `rsp_valid  out  1`: registered response strobe.
- `rsp_id  out  $clog2(NUM_REQ)`: client that issued the request.
- `rsp_data  out  DATA_W`: returned palette index.

## Operation
- **Arbitration**
  - Round-robin pointer `last` holds the most recently granted ID.
  - Search order is `last+1`, `last+2`, …, `last` (mod `NUM_REQ`).
  - The first asserted `req` wins when `en=1`.
  - `grant` has at most one bit set, and is all-zero if `en=0`, `Reset=1` or no request.
- **Handshake**
  - A request is accepted in the cycle where `req[i] && grant[i]`.
  - The client drops `req[i]` or presents its next address the following cycle. Back-to-back requests from one client are legal.
- **Issue stage** (registered on the accept edge):
  - `rom_addr <= req_addr[i]`.
  - `last <= i`.
  - The pipeline tag shift register receives (valid=1, id=i).
- **Idle cycles**
  - With no grant, `rom_addr` holds its previous value.
  - A tag with valid=0 is shifted in.
- **Return stage**
  - The tag is delayed `ROM_LAT+1` stages.
  - When the delayed tag is valid: `rsp_valid <= 1`, `rsp_id <= tag.id`, `rsp_data <= rom_q`.
  - Otherwise `rsp_valid <= 0`, and `rsp_id`/`rsp_data` hold their values.
- **No response backpressure**: clients must accept `rsp_valid` whenever it is asserted.
- **Reset values**
  - `rom_addr = 0`, `rsp_valid = 0`, `rsp_id = 0`, `rsp_data = 0`.
  - `last = NUM_REQ-1`, so client 0 has first priority.
  - All tag valids 0.
- **Reset mid-operation**: all in-flight tags are discarded. No `rsp_valid` appears for requests accepted before the reset edge.
- **`en` falling with requests pending**: no grant while low. `last` is unchanged, so fairness resumes from the same point.

## Timing
- Accept in cycle t:
  - `rom_addr` is valid in t+1.
  - `rom_q` is valid in t+1+`ROM_LAT`.
  - `rsp_valid` is high in t+2+`ROM_LAT`, i.e. 3 cycles for the default.
- Throughput is 1 accept per cycle sustained. Responses return in accept order, one per cycle.
- `grant` is combinational from `req`, `en`, `Reset` and `last`. Clients must not make `req` depend combinationally on `grant`.
- `rsp_*` are registered, with no combinational path from `rom_q` to the outputs.
- Worst-case wait for a continuously requesting client is `NUM_REQ-1` accepts after it asserts `req`.

## Structure
- **Package `sprite_arb_pkg`**
  - Default `ADDR_W`/`DATA_W`/`ROM_LAT` constants.
  - `req_id_t` typedef.
  - Packed struct `arb_tag_t {logic valid; req_id_t id;}`.
- **Sub-module `rr_arbiter`**
  - Combinational round-robin pick: inputs `req`, `en`, `last`; outputs one-hot `grant`, binary `grant_id`, `any_grant`.
  - Reusable by the frame-buffer arbiter.
- **Top**: issue register, tag shift register (`ROM_LAT+1` deep) and response register.

## Test plan
- **Single request.** After reset, `req=4'b0001`, `req_addr[0]=17'h00123` for 1 cycle. Expect `grant=0001` that cycle, `rom_addr=17'h00123` next cycle, and `rsp_valid=1`, `rsp_id=0`, `rsp_data=` ROM model value exactly 3 cycles after accept.
- **Round robin.** Hold `req=4'b1111` for 8 cycles. Expect grant order 0,1,2,3,0,1,2,3 and responses with IDs in the same order on 8 consecutive cycles.
- **Fairness under contention.** Hold `req[0]` and `req[2]` high continuously. Expect grants to alternate 0,2,0,2, and `req[2]` never to wait more than 1 accept.
- **Enable gating.** `en=0` with `req=4'b0110` for 5 cycles. Expect `grant=0` and no `rsp_valid`. On `en=1`, expect client 1 granted first (`last=3` after reset).
- **Reset mid-flight.** Accept 2 requests, then assert `Reset` on the next cycle. Expect `rsp_valid` to stay 0 for 4 cycles, `rom_addr=0`, and the next grant with `req=4'b1111` to go to client 0.
- **Latency parameter.** Rerun the single-request test with `ROM_LAT=2` and a 2-cycle ROM model. Expect `rsp_valid` 4 cycles after accept with the correct data.
